// File: rtl/wavemeas_n_channel.sv
// wavemeas_n_channel: time-multiplexed N-channel waveform period meter.
// Each channel runs a hysteresis crossing detector on its own tagged
// samples and timestamps rising crossings against a free-running counter.
// Finished periods wait in a per-channel slot. A round-robin arbiter moves
// them into a registered valid/ready result port.
// Optional feature macro: MEAS_MINMAX_EN. When it is defined, each channel
// also reports the min/max sample seen over the measured period. When it is
// not defined, res_min/res_max are tied to zero.
module wavemeas_n_channel #(
   parameter int  CH   = 4,
   parameter int  OW   = 12,
   parameter int  CW   = 24,
   parameter int  HYST = 64,
   localparam int CHW  = $clog2(CH)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [CH-1:0]  i_ch_en,
   input  logic           i_samp_valid,
   input  logic [CHW-1:0] i_samp_ch,
   input  logic [OW-1:0]  i_samp_data,
   output logic           o_res_valid,
   input  logic           i_res_ready,
   output logic [CHW-1:0] o_res_ch,
   output logic [CW-1:0]  o_res_period,
   output logic           o_res_overrun,
   output logic [OW-1:0]  o_res_min,
   output logic [OW-1:0]  o_res_max
);

   localparam int          OWX   = OW + 1;
   localparam logic [OW:0] HI_TH = OWX'(2**(OW-1) + HYST);
   localparam logic [OW:0] LO_TH = OWX'(2**(OW-1) - HYST);

   typedef enum logic [1:0] {ST_INIT, ST_LOW, ST_HIGH} state_t;

   state_t         r_state     [CH];
   state_t         w_nextState [CH];
   logic [CW-1:0]  r_lastTs    [CH];
   logic [CW-1:0]  r_per       [CH];
   logic [CH-1:0]  r_hasEdge;
   logic [CH-1:0]  r_pend;
   logic [CH-1:0]  r_ovr;
   logic [CH-1:0]  w_hit;
   logic [CH-1:0]  w_rise;
   logic [CH-1:0]  w_take;
   logic [CW-1:0]  r_ts;
   logic [31:0]    w_chWide;
   logic           w_proc;
   logic           w_isHi;
   logic           w_isLo;
   logic           w_grantValid;
   logic [CHW-1:0] w_grantIdx;
   logic           w_load;
   logic           r_resValid;
   logic [CHW-1:0] r_resCh;
   logic [CW-1:0]  r_resPeriod;
   logic           r_resOvr;

   // The channel tag is widened so that the range check also works when CH is not a power of two.
   assign w_chWide = 32'(i_samp_ch);
   assign w_proc   = i_samp_valid && (w_chWide < 32'(CH)) && i_ch_en[i_samp_ch];
   assign w_isHi   = {1'b0, i_samp_data} >= HI_TH;
   assign w_isLo   = {1'b0, i_samp_data} <= LO_TH;
   assign w_load   = w_grantValid && (!r_resValid || i_res_ready);

   // Decode which channel (if any) owns the processed sample this cycle.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_hit[i] = w_proc && (w_chWide == 32'(i));
      end
   end

   // Free-running timestamp; wraps silently, so very long periods alias.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
      end
   end

   // Crossing FSM next state: band samples hold, INIT settles without recording an edge.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_nextState[i] = r_state[i];
         if (w_hit[i]) begin
            case (r_state[i])
               ST_INIT: begin
                  if (w_isLo)      w_nextState[i] = ST_LOW;
                  else if (w_isHi) w_nextState[i] = ST_HIGH;
               end
               ST_LOW:  if (w_isHi) w_nextState[i] = ST_HIGH;
               ST_HIGH: if (w_isLo) w_nextState[i] = ST_LOW;
               default: w_nextState[i] = ST_INIT;
            endcase
         end
      end
   end

   // Crossing FSM output: only LOW -> HIGH counts as a rising crossing.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_rise[i] = w_hit[i] && (r_state[i] == ST_LOW) && w_isHi;
      end
   end

   // Round-robin search that starts just after the channel granted last.
   always_comb begin : p_arb
      int idx;
      idx          = 0;
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      for (int k = 1; k <= CH; k++) begin
         idx = (int'(r_resCh) + k) % CH;
         if (!w_grantValid && r_pend[idx]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = CHW'(idx);
         end
      end
   end

   // Flag the channel whose pending entry moves into the result register this cycle.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_take[i] = w_load && (w_grantIdx == CHW'(i));
      end
   end

   // Crossing FSM state register plus the per-channel period slot.
   // A fresh crossing always wins over clearing, so the newest period stays pending.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hasEdge <= '0;
         r_pend    <= '0;
         r_ovr     <= '0;
         for (int i = 0; i < CH; i++) begin
            r_state[i]  <= ST_INIT;
            r_lastTs[i] <= '0;
            r_per[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (!i_ch_en[i]) begin
               r_state[i]   <= ST_INIT;
               r_hasEdge[i] <= 1'b0;
               r_pend[i]    <= 1'b0;
               r_ovr[i]     <= 1'b0;
            end else begin
               r_state[i] <= w_nextState[i];
               if (w_rise[i]) begin
                  r_lastTs[i]  <= r_ts;
                  r_hasEdge[i] <= 1'b1;
               end
               if (w_rise[i] && r_hasEdge[i]) begin
                  r_per[i]  <= r_ts - r_lastTs[i];
                  r_pend[i] <= 1'b1;
                  r_ovr[i]  <= r_pend[i] && !w_take[i];
               end else if (w_take[i]) begin
                  r_pend[i] <= 1'b0;
                  r_ovr[i]  <= 1'b0;
               end
            end
         end
      end
   end

`ifdef MEAS_MINMAX_EN
   logic [OW-1:0] r_trkMin [CH];
   logic [OW-1:0] r_trkMax [CH];
   logic [OW-1:0] r_perMin [CH];
   logic [OW-1:0] r_perMax [CH];
   logic [OW-1:0] r_resMin;
   logic [OW-1:0] r_resMax;

   // Min/max tracker: the crossing sample closes the current window and reseeds the next one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < CH; i++) begin
            r_trkMin[i] <= '0;
            r_trkMax[i] <= '0;
            r_perMin[i] <= '0;
            r_perMax[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (w_rise[i]) begin
               r_perMin[i] <= (i_samp_data < r_trkMin[i]) ? i_samp_data : r_trkMin[i];
               r_perMax[i] <= (i_samp_data > r_trkMax[i]) ? i_samp_data : r_trkMax[i];
               r_trkMin[i] <= i_samp_data;
               r_trkMax[i] <= i_samp_data;
            end else if (w_hit[i]) begin
               if (i_samp_data < r_trkMin[i]) r_trkMin[i] <= i_samp_data;
               if (i_samp_data > r_trkMax[i]) r_trkMax[i] <= i_samp_data;
            end
         end
      end
   end

   assign o_res_min = r_resMin;
   assign o_res_max = r_resMax;
`else
   assign o_res_min = '0;
   assign o_res_max = '0;
`endif

   // Result register: loads when empty or being consumed, otherwise holds steady.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_resValid  <= 1'b0;
         r_resCh     <= '0;
         r_resPeriod <= '0;
         r_resOvr    <= 1'b0;
`ifdef MEAS_MINMAX_EN
         r_resMin    <= '0;
         r_resMax    <= '0;
`endif
      end else if (w_load) begin
         r_resValid  <= 1'b1;
         r_resCh     <= w_grantIdx;
         r_resPeriod <= r_per[w_grantIdx];
         r_resOvr    <= r_ovr[w_grantIdx];
`ifdef MEAS_MINMAX_EN
         r_resMin    <= r_perMin[w_grantIdx];
         r_resMax    <= r_perMax[w_grantIdx];
`endif
      end else if (i_res_ready) begin
         r_resValid <= 1'b0;
      end
   end

   assign o_res_valid   = r_resValid;
   assign o_res_ch      = r_resCh;
   assign o_res_period  = r_resPeriod;
   assign o_res_overrun = r_resOvr;

endmodule

// File: tb/tb_wavemeas_n_channel.sv
// tb_wavemeas_n_channel: directed checks for the N-channel period meter
// with CH=4, OW=12, CW=24, HYST=64 (thresholds 2112 / 1984).
// Inputs change 1 time unit after the rising edge. Outputs are read on the
// falling edge. A monitor collects every accepted result into a queue.
module tb_wavemeas_n_channel;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ch_en;
   logic        samp_valid;
   logic [1:0]  samp_ch;
   logic [11:0] samp_data;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_ch;
   logic [23:0] res_period;
   logic        res_overrun;
   logic [11:0] res_min;
   logic [11:0] res_max;

   int compared   = 0;
   int mismatched = 0;

`ifdef MEAS_MINMAX_EN
   localparam logic [11:0] EXP_MIN = 12'd500;
   localparam logic [11:0] EXP_MAX = 12'd3500;
`else
   localparam logic [11:0] EXP_MIN = 12'd0;
   localparam logic [11:0] EXP_MAX = 12'd0;
`endif

   typedef struct {
      logic [1:0]  ch;
      logic [23:0] per;
      logic        ovr;
      logic [11:0] mn;
      logic [11:0] mx;
   } res_t;

   res_t q[$];

   wavemeas_n_channel #(.CH(4), .OW(12), .CW(24), .HYST(64)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_ch_en       (ch_en),
      .i_samp_valid  (samp_valid),
      .i_samp_ch     (samp_ch),
      .i_samp_data   (samp_data),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_ch      (res_ch),
      .o_res_period  (res_period),
      .o_res_overrun (res_overrun),
      .o_res_min     (res_min),
      .o_res_max     (res_max)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Record every result accepted by the consumer
   always @(negedge clk) begin
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1)
         q.push_back('{res_ch, res_period, res_overrun, res_min, res_max});
   end

   // One sample slot: presents the given sample for exactly one cycle
   task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [11:0] d);
      @(posedge clk);
      #1;
      samp_valid = v;
      samp_ch    = c;
      samp_data  = d;
   endtask

   task automatic applyIdle(input int n);
      repeat (n) applyStimulus(1'b0, 2'd0, 12'd0);
   endtask

   function automatic logic [11:0] sineAt(input int t);
      real a;
      a = 2000.0 + 1500.0 * $sin(2.0 * 3.14159265358979323846 * t / 100.0) + 0.5;
      return 12'($rtoi(a));
   endfunction

   // Reset state of every output
   task automatic test_reset();
      rst_n = 1'b0; ch_en = '0; samp_valid = 0; samp_ch = '0; samp_data = '0; res_ready = 0;
      repeat (2) @(negedge clk);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0d expected 0", res_valid); end
      compared++; if (res_ch !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_ch: got %0d expected 0", res_ch); end
      compared++; if (res_period !== 24'd0) begin mismatched++; $display("[TB] FAIL reset_period: got %0d expected 0", res_period); end
      compared++; if (res_overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %0d expected 0", res_overrun); end
      compared++; if (res_min !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_min: got %0d expected 0", res_min); end
      compared++; if (res_max !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_max: got %0d expected 0", res_max); end
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   // ch0 square wave, period 100; second crossing gives the first result two cycles later
   task automatic test_period();
      q.delete(); ch_en = 4'b0001; res_ready = 1'b1;
      repeat (50) applyStimulus(1, 0, 12'd1000);
      repeat (50) applyStimulus(1, 0, 12'd3000);
      repeat (50) applyStimulus(1, 0, 12'd1000);
      applyStimulus(1, 0, 12'd3000);
      @(negedge clk);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_lat_n0: got %0d expected 0", res_valid); end
      applyStimulus(1, 0, 12'd3000);
      @(negedge clk);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_lat_n1: got %0d expected 0", res_valid); end
      applyStimulus(1, 0, 12'd3000);
      @(negedge clk);
      compared++; if (res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL t1_lat_n2: got %0d expected 1", res_valid); end
      compared++; if (res_period !== 24'd100) begin mismatched++; $display("[TB] FAIL t1_first_period: got %0d expected 100", res_period); end
      repeat (47) applyStimulus(1, 0, 12'd3000);
      repeat (50) applyStimulus(1, 0, 12'd1000);
      repeat (50) applyStimulus(1, 0, 12'd3000);
      applyIdle(5);
      compared++; if (q.size() !== 2) begin mismatched++; $display("[TB] FAIL t1_count: got %0d expected 2", q.size()); end
      foreach (q[i]) begin
         compared++; if (q[i].ch !== 2'd0) begin mismatched++; $display("[TB] FAIL t1_ch[%0d]: got %0d expected 0", i, q[i].ch); end
         compared++; if (q[i].per !== 24'd100) begin mismatched++; $display("[TB] FAIL t1_period[%0d]: got %0d expected 100", i, q[i].per); end
         compared++; if (q[i].ovr !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_ovr[%0d]: got %0d expected 0", i, q[i].ovr); end
      end
      ch_en = '0; applyIdle(2);
   endtask

   // ch0 and ch2 interleaved, each 200-cycle square, ch2 a quarter period ahead
   task automatic test_interleave();
      int expCh[6] = '{2, 0, 2, 0, 2, 0};
      q.delete(); ch_en = 4'b0101; res_ready = 1'b1;
      for (int c = 0; c < 800; c++) begin
         int k;
         k = c / 2;
         if (c % 2 == 0) applyStimulus(1, 0, ((k / 50) % 2) ? 12'd3000 : 12'd1000);
         else            applyStimulus(1, 2, (((k + 25) / 50) % 2) ? 12'd3000 : 12'd1000);
      end
      applyIdle(5);
      compared++; if (q.size() !== 6) begin mismatched++; $display("[TB] FAIL t2_count: got %0d expected 6", q.size()); end
      for (int i = 0; i < q.size() && i < 6; i++) begin
         compared++; if (q[i].ch !== 2'(expCh[i])) begin mismatched++; $display("[TB] FAIL t2_ch[%0d]: got %0d expected %0d", i, q[i].ch, expCh[i]); end
         compared++; if (q[i].per !== 24'd200) begin mismatched++; $display("[TB] FAIL t2_period[%0d]: got %0d expected 200", i, q[i].per); end
         compared++; if (q[i].ovr !== 1'b0) begin mismatched++; $display("[TB] FAIL t2_ovr[%0d]: got %0d expected 0", i, q[i].ovr); end
      end
      ch_en = '0; applyIdle(2);
   endtask

   // ch1 period 80 with the consumer stalled: held result stays put, later one reports overrun
   task automatic test_overrun();
      q.delete(); ch_en = 4'b0010; res_ready = 1'b0;
      repeat (4) begin
         repeat (40) applyStimulus(1, 1, 12'd1000);
         repeat (40) applyStimulus(1, 1, 12'd3000);
      end
      applyIdle(3);
      @(negedge clk);
      compared++; if (res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL t3_stall_valid: got %0d expected 1", res_valid); end
      compared++; if (res_ch !== 2'd1) begin mismatched++; $display("[TB] FAIL t3_stall_ch: got %0d expected 1", res_ch); end
      compared++; if (res_period !== 24'd80) begin mismatched++; $display("[TB] FAIL t3_stall_period: got %0d expected 80", res_period); end
      compared++; if (res_overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_stall_ovr: got %0d expected 0", res_overrun); end
      compared++; if (q.size() !== 0) begin mismatched++; $display("[TB] FAIL t3_stall_count: got %0d expected 0", q.size()); end
      @(posedge clk); #1; res_ready = 1'b1;
      applyIdle(5);
      @(negedge clk);
      compared++; if (q.size() !== 2) begin mismatched++; $display("[TB] FAIL t3_count: got %0d expected 2", q.size()); end
      if (q.size() == 2) begin
         compared++; if (q[0].ovr !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_first_ovr: got %0d expected 0", q[0].ovr); end
         compared++; if (q[1].ch !== 2'd1) begin mismatched++; $display("[TB] FAIL t3_second_ch: got %0d expected 1", q[1].ch); end
         compared++; if (q[1].per !== 24'd80) begin mismatched++; $display("[TB] FAIL t3_second_period: got %0d expected 80", q[1].per); end
         compared++; if (q[1].ovr !== 1'b1) begin mismatched++; $display("[TB] FAIL t3_second_ovr: got %0d expected 1", q[1].ovr); end
      end
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_drained: got %0d expected 0", res_valid); end
      ch_en = '0; applyIdle(2);
   endtask

   // ch0 and ch1 both pending while stalled; released results come out on consecutive cycles
   task automatic test_back_to_back();
      q.delete(); ch_en = 4'b0011; res_ready = 1'b0;
      for (int c = 0; c < 80; c++) begin
         int k;
         k = c / 2;
         applyStimulus(1, 2'(c % 2), ((k / 10) % 2) ? 12'd3000 : 12'd1000);
      end
      applyIdle(2);
      @(posedge clk); #1; res_ready = 1'b1;
      @(negedge clk);
      compared++; if (res_valid !== 1'b1 || res_ch !== 2'd0) begin mismatched++; $display("[TB] FAIL b2b_first: got valid=%0d ch=%0d expected valid=1 ch=0", res_valid, res_ch); end
      compared++; if (res_period !== 24'd40) begin mismatched++; $display("[TB] FAIL b2b_first_period: got %0d expected 40", res_period); end
      @(negedge clk);
      compared++; if (res_valid !== 1'b1 || res_ch !== 2'd1) begin mismatched++; $display("[TB] FAIL b2b_second: got valid=%0d ch=%0d expected valid=1 ch=1", res_valid, res_ch); end
      compared++; if (res_period !== 24'd40) begin mismatched++; $display("[TB] FAIL b2b_second_period: got %0d expected 40", res_period); end
      @(negedge clk);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_empty: got %0d expected 0", res_valid); end
      ch_en = '0; applyIdle(2);
   endtask

   // Exact threshold values, a ramp that never reaches the low threshold, and a full ramp
   task automatic test_hysteresis();
      logic [11:0] seq[6] = '{12'd1984, 12'd2111, 12'd2112, 12'd1985, 12'd1984, 12'd2112};
      q.delete(); ch_en = 4'b0001; res_ready = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, seq[i]);
      applyIdle(4);
      compared++; if (q.size() !== 1) begin mismatched++; $display("[TB] FAIL t4_thresh_count: got %0d expected 1", q.size()); end
      if (q.size() == 1) begin
         compared++; if (q[0].per !== 24'd3) begin mismatched++; $display("[TB] FAIL t4_thresh_period: got %0d expected 3", q[0].per); end
      end
      ch_en = '0; applyIdle(2); q.delete(); ch_en = 4'b0001;
      repeat (2) begin
         for (int v = 1990; v < 2150; v++) applyStimulus(1, 0, 12'(v));
         for (int v = 2150; v > 1990; v--) applyStimulus(1, 0, 12'(v));
      end
      applyIdle(4);
      compared++; if (q.size() !== 0) begin mismatched++; $display("[TB] FAIL t4_narrow_count: got %0d expected 0", q.size()); end
      ch_en = '0; applyIdle(2); q.delete(); ch_en = 4'b0001;
      repeat (3) begin
         for (int v = 1900; v < 2200; v++) applyStimulus(1, 0, 12'(v));
         for (int v = 2200; v > 1900; v--) applyStimulus(1, 0, 12'(v));
      end
      applyIdle(4);
      compared++; if (q.size() !== 2) begin mismatched++; $display("[TB] FAIL t4_ramp_count: got %0d expected 2", q.size()); end
      foreach (q[i]) begin
         compared++; if (q[i].per !== 24'd600) begin mismatched++; $display("[TB] FAIL t4_ramp_period[%0d]: got %0d expected 600", i, q[i].per); end
      end
      ch_en = '0; applyIdle(2);
   endtask

   // ch3 disabled mid-period: measurement restarts, needing two fresh crossings
   task automatic test_disable();
      q.delete(); ch_en = 4'b1000; res_ready = 1'b1;
      repeat (2) begin
         repeat (30) applyStimulus(1, 3, 12'd1000);
         repeat (30) applyStimulus(1, 3, 12'd3000);
      end
      applyIdle(4);
      compared++; if (q.size() !== 1) begin mismatched++; $display("[TB] FAIL t5_before_count: got %0d expected 1", q.size()); end
      if (q.size() == 1) begin
         compared++; if (q[0].ch !== 2'd3 || q[0].per !== 24'd60) begin mismatched++; $display("[TB] FAIL t5_before: got ch=%0d per=%0d expected ch=3 per=60", q[0].ch, q[0].per); end
      end
      repeat (15) applyStimulus(1, 3, 12'd1000);
      ch_en = 4'b0000;
      repeat (5) applyStimulus(1, 3, 12'd3000);
      ch_en = 4'b1000;
      repeat (10) applyStimulus(1, 3, 12'd1000);
      repeat (30) applyStimulus(1, 3, 12'd3000);
      @(negedge clk);
      compared++; if (q.size() !== 1) begin mismatched++; $display("[TB] FAIL t5_first_edge: got %0d expected 1", q.size()); end
      repeat (15) applyStimulus(1, 3, 12'd1000);
      repeat (3) applyStimulus(0, 3, 12'd3000);
      repeat (2) applyStimulus(1, 2, 12'd3000);
      repeat (10) applyStimulus(1, 3, 12'd1000);
      repeat (30) applyStimulus(1, 3, 12'd3000);
      applyIdle(4);
      compared++; if (q.size() !== 2) begin mismatched++; $display("[TB] FAIL t5_after_count: got %0d expected 2", q.size()); end
      if (q.size() == 2) begin
         compared++; if (q[1].ch !== 2'd3) begin mismatched++; $display("[TB] FAIL t5_after_ch: got %0d expected 3", q[1].ch); end
         compared++; if (q[1].per !== 24'd60) begin mismatched++; $display("[TB] FAIL t5_after_period: got %0d expected 60", q[1].per); end
         compared++; if (q[1].ovr !== 1'b0) begin mismatched++; $display("[TB] FAIL t5_after_ovr: got %0d expected 0", q[1].ovr); end
      end
      ch_en = '0; applyIdle(2);
   endtask

   // ch0 sine 500..3500 for min/max, then reset asserted while a result is stalled
   task automatic test_minmax_reset();
      q.delete(); ch_en = 4'b0001; res_ready = 1'b1;
      for (int t = 0; t < 330; t++) applyStimulus(1, 0, sineAt(t));
      applyIdle(4);
      compared++; if (q.size() !== 2) begin mismatched++; $display("[TB] FAIL t6_count: got %0d expected 2", q.size()); end
      foreach (q[i]) begin
         compared++; if (q[i].per !== 24'd100) begin mismatched++; $display("[TB] FAIL t6_period[%0d]: got %0d expected 100", i, q[i].per); end
         compared++; if (q[i].mn !== EXP_MIN) begin mismatched++; $display("[TB] FAIL t6_min[%0d]: got %0d expected %0d", i, q[i].mn, EXP_MIN); end
         compared++; if (q[i].mx !== EXP_MAX) begin mismatched++; $display("[TB] FAIL t6_max[%0d]: got %0d expected %0d", i, q[i].mx, EXP_MAX); end
      end
      q.delete(); res_ready = 1'b0;
      for (int t = 330; t < 530; t++) applyStimulus(1, 0, sineAt(t));
      applyIdle(2);
      @(negedge clk);
      compared++; if (res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL t6_stalled: got %0d expected 1", res_valid); end
      @(posedge clk); #1; rst_n = 1'b0;
      #1;
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t6_async_valid: got %0d expected 0", res_valid); end
      compared++; if (res_period !== 24'd0) begin mismatched++; $display("[TB] FAIL t6_async_period: got %0d expected 0", res_period); end
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; res_ready = 1'b1; ch_en = '0;
      applyIdle(5);
      @(negedge clk);
      compared++; if (q.size() !== 0 || res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t6_discarded: got count=%0d valid=%0d expected count=0 valid=0", q.size(), res_valid); end
   endtask

   // Run every scenario in order, then report
   initial begin
      $display("[TB] wavemeas_n_channel bench start");
      test_reset();
      test_period();
      test_interleave();
      test_overrun();
      test_back_to_back();
      test_hysteresis();
      test_disable();
      test_minmax_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
